rvfi_trace_buffer: RTL and testbench
====================================

Name: rvfi_trace_buffer

Overview:
- Multi-lane retirement trace buffer between the CVA6 core's RVFI retire lanes and an off-core trace consumer (formal harness, testbench scoreboard, or debug DMA).
- Accepts up to NRET retired instructions per cycle, each tagged with its raw instruction word.
- Serialises them in program order into a DEPTH-entry FIFO and emits one record per cycle on a valid/ready port.
- Assigns each record a monotonic order number; counts and flags dropped retirements.

Parameters:
- NRET, 2, number of retire lanes presented per cycle (1..4)
- DEPTH, 16, FIFO entries; power of two, >= 2*NRET
- XLEN, 64, PC and register-data width
- ILEN, 32, instruction word width
- CNT_W, 32, width of the drop counter

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  capture enable; when 0, retire lanes are ignored (not counted as drops)
- clear_i  in  1  synchronous flush of FIFO contents and the overflow flag
- ret_valid_i  in  NRET  per-lane retire valid
- ret_pc_i  in  NRET*XLEN  per-lane PC
- ret_insn_i  in  NRET*ILEN  per-lane instruction word
- ret_rd_i  in  NRET*5  per-lane destination register
- ret_rd_wdata_i  in  NRET*XLEN  per-lane write data
- ret_trap_i  in  NRET  per-lane trap flag
- out_valid_o  out  1  head record valid
- out_ready_i  in  1  consumer accepts head record
- out_rec_o  out  rvfi_trace_rec_t  head record: pc, insn, rd, rd_wdata, trap, order[63:0]
- overflow_o  out  1  sticky: at least one retirement was dropped
- drop_cnt_o  out  CNT_W  number of dropped retirements, saturating
- level_o  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_ni=0): FIFO empty, out_valid_o=0, out_rec_o='0, overflow_o=0, drop_cnt_o=0, level_o=0, order counter=0.
- Lane ordering: lane 0 is oldest. Valid lanes are compacted in lane order; gaps (e.g. valid=2'b10) are allowed and skipped.
- Push rule, per cycle with enable_i=1 and clear_i=0:
  - n = popcount(ret_valid_i).
  - free = DEPTH - level_o, using the registered level. A same-cycle pop does not add space.
  - If n <= free: write all n records atomically at consecutive tail slots, with order = order_cnt + k for the k-th compacted lane. Then order_cnt += n.
  - If n > free: push nothing (all-or-nothing), overflow_o <= 1, drop_cnt_o += n saturating at all-ones, order_cnt += n. Order numbers are consumed so the gap is visible downstream.
- Pop rule: a record is removed when out_valid_o && out_ready_i. out_rec_o is driven from the head slot. out_valid_o = (level_o != 0). Output must hold stable while out_valid_o && !out_ready_i.
- Latency: a record pushed in cycle N first appears on the output in cycle N+1; there is no fall-through path.
- Simultaneous push and pop: both take effect; level_o(next) = level_o + pushed - popped.
- Pointers: head and tail are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full is detected when the index bits are equal and the MSBs differ.
- clear_i=1: next cycle FIFO is empty and overflow_o=0. Same-cycle pushes and pops are discarded. order_cnt and drop_cnt_o are retained. clear_i overrides everything except reset.
- enable_i=0: no push and no drop accounting; pops continue normally.
- Reset mid-stream: everything returns to reset values immediately. No partial record is emitted after reset deassertion.

Decomposition:
- Package rvfi_trace_pkg holds:
  - typedef rvfi_trace_rec_t, a packed struct of pc, insn, rd, rd_wdata, trap, order, parametrised by XLEN and ILEN package constants;
  - localparam ORDER_W=64.
- Sub-module rvfi_trace_fifo: multi-push (up to NRET), single-pop FIFO with registered level output.
- The top level owns lane compaction, the order counter, and drop/overflow accounting.

Test Plan:
- NRET=2, both lanes valid, PCs 0x80000000/0x80000004, out_ready_i=1 -> out records in cycles N+1, N+2 with order 0, 1; level returns to 0.
- Lane mask 2'b10 with PC 0x100 -> a single record with PC 0x100 and order 0; lane 0 data ignored.
- out_ready_i=0, push 8 cycles of 2 lanes (DEPTH=16) -> level_o=16. Next 2-lane push -> drop_cnt_o=2, overflow_o=1, level stays 16, head order stays 0.
- Full FIFO, out_ready_i=1 and 2-lane push in the same cycle -> push dropped (free computed from registered level); one pop; level_o=15.
- Mid-stream clear_i pulse with level 5 -> level_o=0, overflow_o=0, next push receives order continuing from order_cnt.
- rst_ni low for 1 cycle during traffic -> all outputs zero asynchronously; the first record after reset has order 0.

Source files
------------

// File: rtl/rvfi_trace_pkg.sv
// Shared types for the RVFI retirement trace buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: ORDER_W, XLEN/ILEN record widths, rvfi_trace_rec_t record layout.
package rvfi_trace_pkg;

  localparam int ORDER_W = 64;
  localparam int XLEN    = 64;
  localparam int ILEN    = 32;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [ILEN-1:0]    insn;
    logic [4:0]         rd;
    logic [XLEN-1:0]    rd_wdata;
    logic               trap;
    logic [ORDER_W-1:0] order;
  } rvfi_trace_rec_t;

endpackage

// File: rtl/rvfi_trace_fifo.sv
// Multi-push (up to NRET per cycle), single-pop trace record FIFO.
// Latency: a record written in cycle N is visible at head_o in cycle N+1.
// Backpressure: caller must only push what fits and only pop when level_o != 0.
// Ports: clk_i/rst_ni, clear_i flush, push_n/push_dat compacted writes,
//        pop, head_o (zero when empty), level_o, full_o.
module rvfi_trace_fifo
  import rvfi_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int NRET  = 2,
  localparam int IW   = $clog2(DEPTH),
  localparam int PW   = IW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic [PW-1:0]   push_n,
  input  rvfi_trace_rec_t push_dat [NRET],
  input  logic            pop,
  output rvfi_trace_rec_t head_o,
  output logic [PW-1:0]   level_o,
  output logic            full_o
);

  rvfi_trace_rec_t mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [IW-1:0]   wr_idx [NRET];

  always_comb begin
    for (int k = 0; k < NRET; k++) begin
      wr_idx[k] = tail[IW-1:0] + IW'(k);
    end
  end

  // Storage is not reset; head_o masks it to zero while empty.
  always_ff @(posedge clk_i) begin
    if (!clear_i) begin
      for (int k = 0; k < NRET; k++) begin
        if (PW'(k) < push_n) mem[wr_idx[k]] <= push_dat[k];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head    <= '0;
      tail    <= '0;
      level_o <= '0;
    end else if (clear_i) begin
      head    <= '0;
      tail    <= '0;
      level_o <= '0;
    end else begin
      tail    <= tail + push_n;
      head    <= head + PW'(pop);
      level_o <= level_o + push_n - PW'(pop);
    end
  end

  // Pointers carry one wrap bit: equal index with differing wrap bit means full.
  assign full_o = (head[IW-1:0] == tail[IW-1:0]) && (head[IW] != tail[IW]);
  assign head_o = (level_o != '0) ? mem[head[IW-1:0]] : '0;

endmodule

// File: rtl/rvfi_trace_buffer.sv
// Multi-lane RVFI retirement trace buffer: compacts lanes, numbers records, counts drops.
// Latency: one cycle from retirement to out_valid_o (no fall-through).
// Backpressure: out_ready_i stalls the head; a retire group that does not fit is
//               dropped whole, still consuming order numbers so the gap is visible.
// Ports: enable_i/clear_i control, ret_*_i NRET retire lanes (lane 0 oldest),
//        out_valid_o/out_ready_i/out_rec_o record stream, overflow_o, drop_cnt_o, level_o.
module rvfi_trace_buffer
  import rvfi_trace_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int DEPTH = 16,
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic                   clear_i,
  input  logic [NRET-1:0]        ret_valid_i,
  input  logic [NRET*XLEN-1:0]   ret_pc_i,
  input  logic [NRET*ILEN-1:0]   ret_insn_i,
  input  logic [NRET*5-1:0]      ret_rd_i,
  input  logic [NRET*XLEN-1:0]   ret_rd_wdata_i,
  input  logic [NRET-1:0]        ret_trap_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output rvfi_trace_rec_t        out_rec_o,
  output logic                   overflow_o,
  output logic [CNT_W-1:0]       drop_cnt_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int NW = $clog2(NRET + 1);

  logic [ORDER_W-1:0] order_cnt;
  logic [NW-1:0]      n;
  logic [NW-1:0]      pos [NRET];
  rvfi_trace_rec_t    cmp_dat [NRET];
  logic [PW-1:0]      free;
  logic               full;
  logic               fits;
  logic               push_req;
  logic               push_ok;
  logic               drop;
  logic               pop;
  logic [PW-1:0]      push_n;
  logic [CNT_W:0]     drop_sum;

  // pos[i] is the compacted slot lane i lands in: count of older valid lanes.
  always_comb begin
    n = '0;
    for (int i = 0; i < NRET; i++) begin
      pos[i] = n;
      n      = n + NW'(ret_valid_i[i]);
    end
  end

  always_comb begin
    for (int k = 0; k < NRET; k++) begin
      cmp_dat[k] = '0;
      for (int i = 0; i < NRET; i++) begin
        if (ret_valid_i[i] && (pos[i] == NW'(k))) begin
          cmp_dat[k].pc       = ret_pc_i[i*XLEN +: XLEN];
          cmp_dat[k].insn     = ret_insn_i[i*ILEN +: ILEN];
          cmp_dat[k].rd       = ret_rd_i[i*5 +: 5];
          cmp_dat[k].rd_wdata = ret_rd_wdata_i[i*XLEN +: XLEN];
          cmp_dat[k].trap     = ret_trap_i[i];
          cmp_dat[k].order    = order_cnt + ORDER_W'(k);
        end
      end
    end
  end

  // Space comes from the registered level only; a same-cycle pop does not help.
  assign free     = PW'(DEPTH) - level_o;
  assign fits     = full ? (n == '0) : (PW'(n) <= free);
  assign push_req = enable_i && !clear_i && (n != '0);
  assign push_ok  = push_req && fits;
  assign drop     = push_req && !fits;
  assign push_n   = push_ok ? PW'(n) : '0;
  assign pop      = out_valid_o && out_ready_i;
  assign drop_sum = {1'b0, drop_cnt_o} + (CNT_W+1)'(n);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      order_cnt  <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (clear_i) begin
      overflow_o <= 1'b0;
    end else if (enable_i) begin
      order_cnt <= order_cnt + ORDER_W'(n);
      if (drop) begin
        overflow_o <= 1'b1;
        drop_cnt_o <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      end
    end
  end

  rvfi_trace_fifo #(
    .DEPTH (DEPTH),
    .NRET  (NRET)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (clear_i),
    .push_n   (push_n),
    .push_dat (cmp_dat),
    .pop      (pop),
    .head_o   (out_rec_o),
    .level_o  (level_o),
    .full_o   (full)
  );

  assign out_valid_o = (level_o != '0);

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Directed bench for rvfi_trace_buffer (NRET=2, DEPTH=16).
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: out_ready_i driven directly per vector.
module tb_rvfi_trace_buffer;
  import rvfi_trace_pkg::*;

  localparam int NRET  = 2;
  localparam int DEPTH = 16;
  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int CNT_W = 32;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   enable_i;
  logic                   clear_i;
  logic [NRET-1:0]        ret_valid_i;
  logic [NRET*XLEN-1:0]   ret_pc_i;
  logic [NRET*ILEN-1:0]   ret_insn_i;
  logic [NRET*5-1:0]      ret_rd_i;
  logic [NRET*XLEN-1:0]   ret_rd_wdata_i;
  logic [NRET-1:0]        ret_trap_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  rvfi_trace_rec_t        out_rec_o;
  logic                   overflow_o;
  logic [CNT_W-1:0]       drop_cnt_o;
  logic [$clog2(DEPTH):0] level_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  rvfi_trace_buffer #(
    .NRET (NRET), .DEPTH (DEPTH), .XLEN (XLEN), .ILEN (ILEN), .CNT_W (CNT_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .enable_i       (enable_i),
    .clear_i        (clear_i),
    .ret_valid_i    (ret_valid_i),
    .ret_pc_i       (ret_pc_i),
    .ret_insn_i     (ret_insn_i),
    .ret_rd_i       (ret_rd_i),
    .ret_rd_wdata_i (ret_rd_wdata_i),
    .ret_trap_i     (ret_trap_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_rec_o      (out_rec_o),
    .overflow_o     (overflow_o),
    .drop_cnt_o     (drop_cnt_o),
    .level_o        (level_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [63:0] pc, input logic [31:0] insn,
                          input logic [4:0] rd, input logic [63:0] wd, input logic trap);
    ret_pc_i[i*XLEN +: XLEN]       = pc;
    ret_insn_i[i*ILEN +: ILEN]     = insn;
    ret_rd_i[i*5 +: 5]             = rd;
    ret_rd_wdata_i[i*XLEN +: XLEN] = wd;
    ret_trap_i[i]                  = trap;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0; enable_i = 1'b1; clear_i = 1'b0; out_ready_i = 1'b0;
    ret_valid_i = '0; ret_pc_i = '0; ret_insn_i = '0; ret_rd_i = '0;
    ret_rd_wdata_i = '0; ret_trap_i = '0;
    step(); step();

    // Reset state
    chk("rst_valid",    64'(out_valid_o), 64'd0);
    chk("rst_level",    64'(level_o),     64'd0);
    chk("rst_overflow", 64'(overflow_o),  64'd0);
    chk("rst_drop",     64'(drop_cnt_o),  64'd0);
    chk("rst_rec_zero", 64'(|out_rec_o),  64'd0);
    rst_ni = 1'b1;

    // Two lanes, consumer ready: records on consecutive cycles, order 0 then 1
    set_lane(0, 64'h8000_0000, 32'h0000_0013, 5'd1, 64'h11, 1'b0);
    set_lane(1, 64'h8000_0004, 32'h0010_0093, 5'd2, 64'h22, 1'b1);
    ret_valid_i = 2'b11; out_ready_i = 1'b1;
    step();
    ret_valid_i = 2'b00;
    chk("two_valid",   64'(out_valid_o),       64'd1);
    chk("two_level",   64'(level_o),           64'd2);
    chk("two_pc0",     out_rec_o.pc,           64'h8000_0000);
    chk("two_insn0",   64'(out_rec_o.insn),    64'h13);
    chk("two_rd0",     64'(out_rec_o.rd),      64'd1);
    chk("two_ord0",    out_rec_o.order,        64'd0);
    step();
    chk("two_pc1",     out_rec_o.pc,           64'h8000_0004);
    chk("two_wd1",     out_rec_o.rd_wdata,     64'h22);
    chk("two_trap1",   64'(out_rec_o.trap),    64'd1);
    chk("two_ord1",    out_rec_o.order,        64'd1);
    step();
    chk("two_empty",   64'(level_o),           64'd0);
    chk("two_novalid", 64'(out_valid_o),       64'd0);

    // Gap in lane mask: only lane 1 is captured
    do_reset();
    set_lane(0, 64'hdead, 32'hffff_ffff, 5'd31, 64'hbad, 1'b1);
    set_lane(1, 64'h100, 32'h0000_0073, 5'd5, 64'h55, 1'b0);
    ret_valid_i = 2'b10; out_ready_i = 1'b1;
    step();
    ret_valid_i = 2'b00;
    chk("gap_level", 64'(level_o),        64'd1);
    chk("gap_pc",    out_rec_o.pc,        64'h100);
    chk("gap_rd",    64'(out_rec_o.rd),   64'd5);
    chk("gap_ord",   out_rec_o.order,     64'd0);
    step();
    chk("gap_empty", 64'(level_o),        64'd0);

    // Fill to DEPTH with the consumer stalled, then overflow
    do_reset();
    set_lane(0, 64'h1000, 32'h13, 5'd1, 64'h1, 1'b0);
    set_lane(1, 64'h1004, 32'h13, 5'd2, 64'h2, 1'b0);
    out_ready_i = 1'b0; ret_valid_i = 2'b11;
    for (int c = 0; c < 8; c++) step();
    chk("fill_level", 64'(level_o),     64'd16);
    chk("fill_ovf",   64'(overflow_o),  64'd0);
    step();
    chk("ovf_drop",   64'(drop_cnt_o),  64'd2);
    chk("ovf_flag",   64'(overflow_o),  64'd1);
    chk("ovf_level",  64'(level_o),     64'd16);
    chk("ovf_head",   out_rec_o.order,  64'd0);

    // Full with same-cycle pop: push still dropped, one record leaves
    out_ready_i = 1'b1;
    step();
    ret_valid_i = 2'b00;
    chk("fullpop_level", 64'(level_o),    64'd15);
    chk("fullpop_drop",  64'(drop_cnt_o), 64'd4);
    chk("fullpop_head",  out_rec_o.order, 64'd1);

    // Drain to 5, then clear; order numbering continues from 20
    for (int c = 0; c < 10; c++) step();
    chk("drain_level", 64'(level_o),    64'd5);
    chk("drain_head",  out_rec_o.order, 64'd11);
    out_ready_i = 1'b0; clear_i = 1'b1; ret_valid_i = 2'b11;
    step();
    clear_i = 1'b0;
    chk("clr_level", 64'(level_o),     64'd0);
    chk("clr_ovf",   64'(overflow_o),  64'd0);
    chk("clr_valid", 64'(out_valid_o), 64'd0);
    chk("clr_drop",  64'(drop_cnt_o),  64'd4);
    step();
    ret_valid_i = 2'b00;
    chk("clr_push_level", 64'(level_o),    64'd2);
    chk("clr_push_ord",   out_rec_o.order, 64'd20);
    out_ready_i = 1'b1;
    step();
    chk("clr_push_ord2",  out_rec_o.order, 64'd21);

    // enable_i low: lanes ignored, no drop accounting
    enable_i = 1'b0; ret_valid_i = 2'b11;
    step();
    chk("dis_level", 64'(level_o),    64'd0);
    chk("dis_drop",  64'(drop_cnt_o), 64'd4);
    enable_i = 1'b1;

    // Asynchronous reset during traffic
    step();
    chk("pre_rst_valid", 64'(out_valid_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid_o), 64'd0);
    chk("arst_level", 64'(level_o),     64'd0);
    chk("arst_drop",  64'(drop_cnt_o),  64'd0);
    chk("arst_rec",   64'(|out_rec_o),  64'd0);
    step();
    ret_valid_i = 2'b00;
    rst_ni = 1'b1;
    step();
    chk("post_rst_level", 64'(level_o), 64'd0);
    set_lane(0, 64'h200, 32'h13, 5'd3, 64'h3, 1'b0);
    ret_valid_i = 2'b01;
    step();
    ret_valid_i = 2'b00;
    chk("post_rst_pc",  out_rec_o.pc,    64'h200);
    chk("post_rst_ord", out_rec_o.order, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
